// File: rtl/layer1_pixel_streamer_pkg.sv
// Shared constants and state encoding for the Layer 1 pixel streamer.
// PIXEL_BINARIZE_EN selects thresholded pixels instead of raw image data.
package layer1_pixel_streamer_pkg;

    localparam int L1_PIXEL_W    = 8;    // inputWidth
    localparam int L1_NUM_PIXELS = 784;  // numWeightLayer1
    localparam int L1_ADDR_W     = 10;
    localparam int L1_THRESH     = 128;

`ifdef PIXEL_BINARIZE_EN
    localparam bit L1_BINARIZE = 1'b1;
`else
    localparam bit L1_BINARIZE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } l1_state_t;

endpackage

// File: rtl/layer1_pixel_streamer_image_buffer.sv
// Image store with one write port and one registered read port; the read
// register doubles as the pixel output register and is zero whenever no read is issued.
module image_buffer
    import layer1_pixel_streamer_pkg::*;
#(
    parameter int PIXEL_W    = L1_PIXEL_W,
    parameter int NUM_PIXELS = L1_NUM_PIXELS,
    parameter int ADDR_W     = L1_ADDR_W,
    parameter int THRESH     = L1_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [PIXEL_W-1:0] THRESH_V  = PIXEL_W'(THRESH);

    logic [PIXEL_W-1:0] mem [NUM_PIXELS];
    logic [PIXEL_W-1:0] rd_raw;
    logic [PIXEL_W-1:0] rd_fmt;

    // Contents are deliberately not reset so an image survives a pass abort.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_raw = mem[rd_addr];

    always_comb begin
        rd_fmt = rd_raw;
        if (L1_BINARIZE) begin
            rd_fmt = (rd_raw >= THRESH_V) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
        end
    end

    // Zero outside reads keeps Layer 1 accumulators frozen between passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_fmt;
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/layer1_pixel_streamer.sv
// Streams one buffered 28x28 image into Layer 1: one clear cycle, 784 pixel cycles, one done pulse.
// Optional PIXEL_BINARIZE_EN thresholds pixels in the output register at no extra latency.
module layer1_pixel_streamer
    import layer1_pixel_streamer_pkg::*;
#(
    parameter int PIXEL_W    = L1_PIXEL_W,
    parameter int NUM_PIXELS = L1_NUM_PIXELS,
    parameter int ADDR_W     = L1_ADDR_W,
    parameter int THRESH     = L1_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               l1_clear,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic [ADDR_W-1:0]  addr_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    l1_state_t         state;
    l1_state_t         state_nxt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              buf_wr_en;

    // addr_out is the pixel counter itself; it sits at 0 outside STREAM.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = addr_out;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                rd_en     = 1'b1;
                rd_addr   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (addr_out == LAST_ADDR) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DONE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = addr_out + 1'b1;
                    cnt_nxt = addr_out + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            l1_clear <= 1'b1;
        end else begin
            state    <= state_nxt;
            addr_out <= cnt_nxt;
            busy     <= (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM);
            done     <= (state_nxt == ST_DONE);
            l1_clear <= (state_nxt == ST_CLEAR);
        end
    end

    // A write coinciding with start lands before the first read one cycle later.
    assign buf_wr_en = wr_en && !busy;

    image_buffer #(
        .PIXEL_W    (PIXEL_W),
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W),
        .THRESH     (THRESH)
    ) u_image_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (pixel_out)
    );

endmodule

// File: tb/tb_layer1_pixel_streamer.sv
// Self-checking bench for layer1_pixel_streamer against a cycle-indexed reference of one pass.
module tb_layer1_pixel_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       l1_clear;
    logic [7:0] pixel_out;
    logic [9:0] addr_out;

    int n_checks = 0;
    int n_pass   = 0;
    int img [784];

    always #5 clk = ~clk;

    layer1_pixel_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .l1_clear  (l1_clear),
        .pixel_out (pixel_out),
        .addr_out  (addr_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] pack(input logic b, input logic d, input logic c,
                                         input logic [7:0] px, input logic [9:0] ad);
        return {11'd0, b, d, c, px, ad};
    endfunction

    function automatic logic [7:0] fmt(input int v);
`ifdef PIXEL_BINARIZE_EN
        return (v >= 128) ? 8'hFF : 8'h00;
`else
        return v[7:0];
`endif
    endfunction

    // Expected outputs k cycles after the edge that sampled start.
    function automatic logic [31:0] exp_vec(input int k, input int rst_k);
        int i;
        if (rst_k > 0 && k == rst_k + 1) return pack(1'b0, 1'b0, 1'b1, 8'd0, 10'd0);
        if (rst_k > 0 && k > rst_k + 1)  return pack(1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
        if (k == 1) return pack(1'b1, 1'b0, 1'b1, 8'd0, 10'd0);
        if (k >= 2 && k <= 785) begin
            i = k - 2;
            return pack(1'b1, 1'b0, 1'b0, fmt(img[i]), i[9:0]);
        end
        if (k == 786) return pack(1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
        return pack(1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
    endfunction

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = a[9:0];
        wr_data = d[7:0];
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 784) img[a] = d;
    endtask

    // One pass; optional same-cycle write with start, write/start/reset injected at cycle k.
    task automatic run_pass(input string name, input int pre_addr, input int pre_data,
                            input int wr_k, input int st_k, input int rst_k);
        int busy_n = 0;
        if (pre_addr >= 0) begin
            wr_en   = 1'b1;
            wr_addr = pre_addr[9:0];
            wr_data = pre_data[7:0];
            img[pre_addr] = pre_data;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 1; k <= 790; k++) begin
            check($sformatf("%s_cyc%0d", name, k),
                  pack(busy, done, l1_clear, pixel_out, addr_out), exp_vec(k, rst_k));
            if (busy) busy_n++;
            wr_en   = (k == wr_k);
            wr_addr = 10'd5;
            wr_data = 8'hFF;
            start   = (k == st_k);
            rst     = (rst_k > 0 && k == rst_k);
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
        rst   = 1'b0;
        if (rst_k <= 0) check({name, "_busy_len"}, busy_n, 785);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", pack(busy, done, l1_clear, pixel_out, addr_out),
              pack(1'b0, 1'b0, 1'b1, 8'd0, 10'd0));
        rst = 1'b0;
        @(negedge clk);
        check("idle", pack(busy, done, l1_clear, pixel_out, addr_out),
              pack(1'b0, 1'b0, 1'b0, 8'd0, 10'd0));

        for (int i = 0; i < 784; i++) wr(i, i % 256);
        run_pass("basic", -1, 0, 0, 0, 0);

        for (int i = 0; i < 784; i++) wr(i, int'($urandom_range(0, 255)));
        wr(1, 127);
        wr(2, 128);
        wr(3, 255);
        run_pass("ignored", -1, 0, 12, 22, 0);

        run_pass("abort", -1, 0, 0, 0, 302);
        run_pass("fresh", -1, 0, 0, 0, 0);

        wr(784, 8'h5A);
        wr(1023, 8'hA5);
        wr(783, 8'h3C);
        run_pass("bound", 0, int'($urandom_range(0, 255)), 0, 786, 0);

        for (int i = 0; i < 784; i++) wr(i, 0);
        wr(0, 1);
        run_pass("onehot", -1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer1_pixel_streamer.md
# layer1_pixel_streamer

Producer side of the Layer 1 pixel interface. Holds one 28x28 image in an internal buffer loaded over a simple write port. On `start` it clears the Layer 1 accumulators to bias for one cycle, then drives one pixel and its weight address per cycle for all 784 pixels. It ends with a one-cycle `done` pulse that marks `layer_out` of Layer 1 as valid. Sits between the image loader (UART/testbench writer) and the Layer 1 MAC array.

## Interface
- `PIXEL_W`, default `inputWidth` (8): pixel width; must match the Layer 1 pixel input.
- `NUM_PIXELS`, default `numWeightLayer1` (784): pixels per image.
- `ADDR_W`, default 10: pixel/weight address width.
- `THRESH`, default 128: binarization threshold (used only with the macro in Configuration).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  image buffer write strobe.
- `wr_addr`  in  ADDR_W  buffer write address.
- `wr_data`  in  PIXEL_W  pixel to write, unsigned.
- `start`  in  1  request one streaming pass.
- `busy`  out  1  high from the cycle after an accepted `start` through the last pixel cycle.
- `done`  out  1  one-cycle pulse; Layer 1 outputs are valid from this cycle.
- `l1_clear`  out  1  drives Layer 1 reset (loads bias into the accumulators).
- `pixel_out`  out  PIXEL_W  pixel to Layer 1.
- `addr_out`  out  ADDR_W  weight address to Layer 1, aligned with `pixel_out`.

## Operation
- States: IDLE, CLEAR, STREAM, DONE.
- **IDLE**
  - Outputs: `pixel_out`=0, `addr_out`=0, `l1_clear`=0, `busy`=0.
  - `start`=1 moves to CLEAR.
- **CLEAR** (1 cycle)
  - Outputs: `l1_clear`=1, `busy`=1, `pixel_out`=0.
  - The buffer read of address 0 is issued.
  - Next state: STREAM.
- **STREAM** (NUM_PIXELS cycles)
  - Pixel i (0..783) is presented as `pixel_out`=img[i] with `addr_out`=i.
  - `l1_clear`=0.
  - The read counter increments each cycle.
  - After i=NUM_PIXELS-1 the state moves to DONE; the counter returns to 0 and does not wrap into a second pass.
- **DONE** (1 cycle)
  - Outputs: `done`=1, `busy`=0, `pixel_out`=0.
  - Next state: IDLE.
- Zero pixels outside STREAM are mandatory. Layer 1 accumulates every cycle it is not cleared, and a zero pixel adds nothing, so `layer_out` stays stable after `done` until the next CLEAR.
- Writes
  - Accepted only when the state is IDLE, DONE, or in reset recovery, i.e. whenever `busy`=0.
  - `wr_en` while `busy`=1 is ignored.
  - `wr_addr` >= NUM_PIXELS is ignored.
- `start` in any state other than IDLE is ignored. `start` in the DONE cycle is dropped; it must be reasserted in IDLE.
- `start` and `wr_en` in the same IDLE cycle: the write completes and the pass starts. The read of that address sees the new data, because reads begin one cycle later.
- Buffer contents persist across passes and across reset; they are not cleared.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pixel_out`=0, `addr_out`=0, `l1_clear`=1 during the reset cycle. Read counter 0.
- Reset mid-pass aborts to IDLE. Layer 1 is cleared, `done` is not issued, and the next `start` begins a full pass.
- All outputs are registered. The buffer uses a synchronous read with 1-cycle latency, hidden by CLEAR.
- With `start` sampled high at edge E0:
  - cycle E0+1: CLEAR;
  - cycles E0+2 .. E0+785: pixels 0..783;
  - cycle E0+786: `done`.
- Pass latency: 786 cycles from `start` to `done`. The minimum start-to-start interval is 787 cycles.

## Configuration
- `PIXEL_BINARIZE_EN` defined:
  - `pixel_out` = {PIXEL_W{1'b1}} when img[i] >= THRESH, else 0.
  - Applied in the output register, so there is no added latency.
- `PIXEL_BINARIZE_EN` undefined: `pixel_out` = img[i] unmodified, and THRESH is unused.

## Structure
- Shared constants, from the existing `config.v` macros or a shared package:
  - NUM_PIXELS (`numWeightLayer1`), PIXEL_W (`inputWidth`), ADDR_W;
  - state encoding (2-bit IDLE=0, CLEAR=1, STREAM=2, DONE=3).
- One sub-module, `image_buffer`:
  - NUM_PIXELS x PIXEL_W;
  - one write port and one synchronous read port.
- FSM, counter and output registers stay in the top module.

## Test plan
- **Basic pass.** Load img[i]=i mod 256, pulse `start`. Expect:
  - `l1_clear`=1 for exactly 1 cycle;
  - then 784 cycles with `addr_out`=i and `pixel_out`=i mod 256;
  - `done` pulse at start+786;
  - `busy` high for exactly 785 cycles.
- **End-to-end with Layer 1.** All-zero image except img[0]=1. Expect Layer 1 neuron n = ReLU(bias[n] + w[n*784]). `layer_out` unchanged for 100 cycles after `done`.
- **Ignored requests during a pass.**
  - `wr_en` to addr 5 with 0xFF at STREAM cycle 10: buffer unchanged.
  - `start` at cycle 20: no restart; `done` still at start+786.
- **Reset mid-pass.** Assert `rst` at STREAM pixel 300. Expect:
  - outputs at reset values next cycle;
  - no `done`;
  - a fresh `start` yields the full 784-pixel sequence from addr 0.
- **Address boundaries.**
  - Write to addr 784 and 1023: no effect.
  - Write to addr 783: appears as the last pixel with `addr_out`=783.
- **`PIXEL_BINARIZE_EN` defined, THRESH=128.** Pixels 127, 128, 255 stream as 0x00, 0xFF, 0xFF.
